projectile_pool: RTL and testbench

Parametrised projectile engine for the two-player shooter game: one instance per shooter. It owns a pool of N_SLOTS balls, spawns them on shoot presses subject to cooldown, moves them every game tick, detects hits against the opposing sprite (with shield blocking), and keeps the target's health. Its outputs feed the display renderer (per-slot enable/X/Y) and the game-over logic (target_alive).

---
 rtl/projectile_pool.sv | 164 ++++++++++++++++
 tb/tb_projectile_pool.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// Ball pool for one shooter: spawns on button presses, moves balls each game tick,
// resolves hits against the opposing sprite and tracks that sprite's health.
module projectile_pool #(
  parameter int N_SLOTS    = 9,
  parameter int DIR        = 0,
  parameter int SPEED      = 2,
  parameter int SPAWN_X    = 22,
  parameter int Y_OFFSET   = 7,
  parameter int BALL_W     = 6,
  parameter int BALL_H     = 6,
  parameter int TARGET_X   = 74,
  parameter int TARGET_W   = 22,
  parameter int TARGET_H   = 20,
  parameter int SCREEN_W   = 96,
  parameter int COOLDOWN   = 4,
  parameter int DAMAGE     = 10,
  parameter int MAX_HEALTH = 100
) (
  input  logic                   clk_20Hz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   shoot,
  input  logic [5:0]             shooter_top_y,
  input  logic [5:0]             target_top_y,
  input  logic                   shield_on,
  output logic [N_SLOTS-1:0]     ball_en,
  output logic [7*N_SLOTS-1:0]   ball_x,
  output logic [6*N_SLOTS-1:0]   ball_y,
  output logic                   hit_pulse,
  output logic                   blocked_pulse,
  output logic [7:0]             target_health,
  output logic                   target_alive,
  output logic                   pool_full
);

  localparam logic [7:0]  SPD     = 8'(SPEED);
  localparam logic [7:0]  BW_M1   = 8'(BALL_W - 1);
  localparam logic [7:0]  BH_M1   = 8'(BALL_H - 1);
  localparam logic [7:0]  TH_M1   = 8'(TARGET_H - 1);
  localparam logic [7:0]  TX      = 8'(TARGET_X);
  localparam logic [7:0]  TX_END  = 8'(TARGET_X + TARGET_W - 1);
  localparam logic [7:0]  X_LIMIT = 8'(SCREEN_W - BALL_W);
  localparam logic [7:0]  Y_MAX   = 8'(64 - BALL_H);
  localparam logic [7:0]  Y_OFF   = 8'(Y_OFFSET);
  localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN);
  localparam logic [6:0]  SX      = 7'(SPAWN_X);
  localparam logic [15:0] DMG     = 16'(DAMAGE);

  typedef enum logic {RUN, OVER} state_t;

  state_t                 state, state_next;
  logic                   shoot_q;
  logic [7:0]             cooldown, cd_next, hp_next;
  logic [N_SLOTS-1:0]     en_next, free_mask, spawn_mask;
  logic [7*N_SLOTS-1:0]   x_next;
  logic [6*N_SLOTS-1:0]   y_next;
  logic                   hit_next, blk_next, press, spawn_ok;
  logic [4:0]             hits;
  logic [15:0]            dmg;
  logic [7:0]             spawn_y8, ty8;
  logic [5:0]             spawn_y;
  logic [7:0]             xc, xn, yc;
  logic                   vert, horiz;

  assign press      = shoot & ~shoot_q;
  assign free_mask  = ~ball_en;
  // Isolate the lowest free slot as a one-hot mask.
  assign spawn_mask = free_mask & (~free_mask + N_SLOTS'(1));
  assign spawn_y8   = {2'b00, shooter_top_y} + Y_OFF;
  assign spawn_y    = (spawn_y8 > Y_MAX) ? Y_MAX[5:0] : spawn_y8[5:0];
  assign ty8        = {2'b00, target_top_y};
  assign spawn_ok   = press & enable & (state == RUN) & (cooldown == 8'd0) & (|free_mask);

  always_comb begin
    state_next = state;
    en_next    = ball_en;
    x_next     = ball_x;
    y_next     = ball_y;
    cd_next    = cooldown;
    hp_next    = target_health;
    hit_next   = 1'b0;
    blk_next   = 1'b0;
    hits       = 5'd0;
    dmg        = 16'd0;
    xc         = 8'd0;
    xn         = 8'd0;
    yc         = 8'd0;
    vert       = 1'b0;
    horiz      = 1'b0;
    if (state == OVER) begin
      en_next = '0;
    end else if (enable) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (ball_en[i]) begin
          xc   = {1'b0, ball_x[7*i +: 7]};
          yc   = {2'b00, ball_y[6*i +: 6]};
          xn   = (DIR == 0) ? (xc + SPD) : (xc - SPD);
          vert = (yc <= ty8 + TH_M1) && (yc + BH_M1 >= ty8);
          horiz = (DIR == 0) ? (xn + BW_M1 >= TX) : (xn <= TX_END);
          if (vert && horiz) begin
            en_next[i] = 1'b0;
            hits       = hits + 5'd1;
          end else if ((DIR == 0) ? (xn > X_LIMIT) : (xc < SPD)) begin
            en_next[i] = 1'b0;
          end else begin
            x_next[7*i +: 7] = xn[6:0];
          end
        end
      end
      if (hits != 5'd0) begin
        if (shield_on) begin
          blk_next = 1'b1;
        end else begin
          hit_next = 1'b1;
          dmg      = {11'd0, hits} * DMG;
          hp_next  = ({8'd0, target_health} <= dmg) ? 8'd0 : (target_health - dmg[7:0]);
        end
      end
      // Spawn only into a slot that was already free at the start of the tick.
      if (spawn_ok) begin
        cd_next = CD_LOAD;
        for (int i = 0; i < N_SLOTS; i++) begin
          if (spawn_mask[i]) begin
            en_next[i]       = 1'b1;
            x_next[7*i +: 7] = SX;
            y_next[6*i +: 6] = spawn_y;
          end
        end
      end else if (cooldown != 8'd0) begin
        cd_next = cooldown - 8'd1;
      end
      if (hp_next == 8'd0) state_next = OVER;
    end
  end

  always_ff @(posedge clk_20Hz) begin
    if (reset) begin
      state         <= RUN;
      shoot_q       <= 1'b0;
      cooldown      <= 8'd0;
      ball_en       <= '0;
      ball_x        <= '0;
      ball_y        <= '0;
      hit_pulse     <= 1'b0;
      blocked_pulse <= 1'b0;
      target_health <= 8'(MAX_HEALTH);
      target_alive  <= 1'b1;
      pool_full     <= 1'b0;
    end else begin
      state         <= state_next;
      shoot_q       <= shoot;
      cooldown      <= cd_next;
      ball_en       <= en_next;
      ball_x        <= x_next;
      ball_y        <= y_next;
      hit_pulse     <= hit_next;
      blocked_pulse <= blk_next;
      target_health <= hp_next;
      target_alive  <= (hp_next != 8'd0);
      pool_full     <= &en_next;
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: per-tick scoreboard against a slot-array game model,
// plus directed scenarios and a second instance with zero cooldown for pool filling.
module tb_projectile_pool;

  localparam int N          = 9;
  localparam int DIR        = 0;
  localparam int SPEED      = 2;
  localparam int SPAWN_X    = 22;
  localparam int Y_OFFSET   = 7;
  localparam int BALL_W     = 6;
  localparam int BALL_H     = 6;
  localparam int TARGET_X   = 74;
  localparam int TARGET_W   = 22;
  localparam int TARGET_H   = 20;
  localparam int SCREEN_W   = 96;
  localparam int COOLDOWN   = 4;
  localparam int DAMAGE     = 10;
  localparam int MAX_HEALTH = 100;
  localparam int W          = N + 7*N + 6*N + 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, enable = 1'b0, shoot = 1'b0, shield_on = 1'b0;
  logic [5:0]     shooter_top_y = 6'd0, target_top_y = 6'd0;
  logic [N-1:0]   ball_en;
  logic [7*N-1:0] ball_x;
  logic [6*N-1:0] ball_y;
  logic           hit_pulse, blocked_pulse, target_alive, pool_full;
  logic [7:0]     target_health;

  logic [5:0]     ty2 = 6'd40;
  logic           shield2 = 1'b0;
  logic [N-1:0]   en2;
  logic [7*N-1:0] x2;
  logic [6*N-1:0] y2;
  logic           hit2, blk2, alive2, full2;
  logic [7:0]     hp2;

  projectile_pool dut (
    .clk_20Hz(clk), .reset(reset), .enable(enable), .shoot(shoot),
    .shooter_top_y(shooter_top_y), .target_top_y(target_top_y), .shield_on(shield_on),
    .ball_en(ball_en), .ball_x(ball_x), .ball_y(ball_y),
    .hit_pulse(hit_pulse), .blocked_pulse(blocked_pulse),
    .target_health(target_health), .target_alive(target_alive), .pool_full(pool_full)
  );

  projectile_pool #(.COOLDOWN(0)) dut_nocd (
    .clk_20Hz(clk), .reset(reset), .enable(enable), .shoot(shoot),
    .shooter_top_y(shooter_top_y), .target_top_y(ty2), .shield_on(shield2),
    .ball_en(en2), .ball_x(x2), .ball_y(y2),
    .hit_pulse(hit2), .blocked_pulse(blk2),
    .target_health(hp2), .target_alive(alive2), .pool_full(full2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // behavioural game model
  int m_x[N];
  int m_y[N];
  bit m_act[N];
  int m_hp, m_cd;
  bit m_over, m_prev, m_hit, m_blk;

  int c_sy = 0, c_ty = 0;
  logic c_sh = 1'b0;

  task automatic model_step(input logic r, input logic e, input logic s,
                            input int sy, input int ty, input logic shd);
    int k, xn, fs;
    bit press, vert, horiz;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_hp = MAX_HEALTH; m_cd = 0; m_over = 0; m_prev = 0; m_hit = 0; m_blk = 0;
      return;
    end
    press  = s && !m_prev;
    m_prev = s;
    m_hit  = 0;
    m_blk  = 0;
    if (m_over) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      return;
    end
    if (!e) return;
    fs = -1;
    for (int i = 0; i < N; i++) if (!m_act[i] && fs < 0) fs = i;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        xn    = (DIR == 0) ? ((m_x[i] + SPEED) & 255) : ((m_x[i] - SPEED) & 255);
        vert  = (m_y[i] <= ty + TARGET_H - 1) && (m_y[i] + BALL_H - 1 >= ty);
        horiz = (DIR == 0) ? (xn + BALL_W - 1 >= TARGET_X) : (xn <= TARGET_X + TARGET_W - 1);
        if (vert && horiz) begin
          m_act[i] = 0; k++;
        end else if ((DIR == 0) ? (xn > SCREEN_W - BALL_W) : (m_x[i] < SPEED)) begin
          m_act[i] = 0;
        end else begin
          m_x[i] = xn;
        end
      end
    end
    if (k > 0) begin
      if (shd) m_blk = 1;
      else begin
        m_hit = 1;
        m_hp  = (m_hp - k*DAMAGE < 0) ? 0 : m_hp - k*DAMAGE;
      end
    end
    if (press && m_cd == 0 && fs >= 0) begin
      m_act[fs] = 1;
      m_x[fs]   = SPAWN_X;
      m_y[fs]   = (sy + Y_OFFSET > 64 - BALL_H) ? 64 - BALL_H : sy + Y_OFFSET;
      m_cd      = COOLDOWN;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    if (m_hp == 0) m_over = 1;
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [N-1:0]   e;
    logic [7*N-1:0] xv;
    logic [6*N-1:0] yv;
    bit full;
    full = 1;
    for (int i = 0; i < N; i++) begin
      e[i]        = m_act[i];
      xv[7*i +: 7] = 7'(m_x[i]);
      yv[6*i +: 6] = 6'(m_y[i]);
      if (!m_act[i]) full = 0;
    end
    return {e, xv, yv, m_hit, m_blk, 8'(m_hp), (m_hp != 0), full};
  endfunction

  // driver tasks
  task automatic drive(input logic r, input logic e, input logic s);
    @(negedge clk);
    reset         = r;
    enable        = e;
    shoot         = s;
    shooter_top_y = 6'(c_sy);
    target_top_y  = 6'(c_ty);
    shield_on     = c_sh;
    model_step(r, e, s, c_sy, c_ty, c_sh);
    exp_q.push_back(model_vec());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {ball_en, ball_x, ball_y, hit_pulse, blocked_pulse,
                 target_health, target_alive, pool_full};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL tick_state t=%0t act=%h exp=%h", $time, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    repeat (3) drive(1, 1, 0);
    settle();
    check("reset_health", target_health, MAX_HEALTH);
    check("reset_alive", target_alive, 1);
    check("reset_en", ball_en, 0);

    // zero-cooldown instance fills all slots; 10th press dropped
    c_sy = 20; c_ty = 40;
    for (int p = 0; p < 10; p++) begin
      drive(0, 1, 1);
      drive(0, 1, 0);
      if (p == 7) begin
        settle();
        check("nocd_not_full_8", full2, 0);
      end
    end
    settle();
    check("nocd_pool_full", full2, 1);
    check("nocd_all_en", en2, 9'h1ff);
    repeat (2) drive(1, 1, 0);

    // single shot that hits
    c_sy = 20; c_ty = 20;
    drive(0, 1, 1);
    settle();
    check("spawn_x", ball_x[6:0], 22);
    check("spawn_y", ball_y[5:0], 27);
    repeat (29) drive(0, 1, 0);
    settle();
    check("hit_health", target_health, 90);
    check("hit_freed", ball_en, 0);

    // shielded hit
    c_sh = 1'b1;
    drive(0, 1, 1);
    repeat (29) drive(0, 1, 0);
    settle();
    check("shield_health", target_health, 90);
    c_sh = 1'b0;

    // vertical miss flies off screen
    c_ty = 40;
    drive(0, 1, 1);
    repeat (39) drive(0, 1, 0);
    settle();
    check("miss_health", target_health, 90);
    check("miss_freed", ball_en, 0);

    // cooldown: presses at 0,2,4,6 -> two spawns
    for (int t = 0; t < 8; t++) drive(0, 1, (t % 2 == 0));
    settle();
    check("cooldown_spawns", ball_en, 9'b000000011);
    repeat (40) drive(0, 1, 0);

    // drain health to 10
    c_ty = 20;
    repeat (8) begin
      drive(0, 1, 1);
      repeat (5) drive(0, 1, 0);
    end
    repeat (30) drive(0, 1, 0);
    settle();
    check("drain_health", target_health, 10);

    // two balls hit the same tick, a third is still flying
    c_ty = 40; c_sy = 6;
    drive(0, 1, 1);
    repeat (5) drive(0, 1, 0);
    c_sy = 20;
    drive(0, 1, 1);
    repeat (5) drive(0, 1, 0);
    c_sy = 40;
    drive(0, 1, 1);
    repeat (17) drive(0, 1, 0);
    c_ty = 13;
    drive(0, 1, 0);
    settle();
    check("double_health", target_health, 0);
    check("double_alive", target_alive, 0);
    check("double_pulse", hit_pulse, 1);
    check("survivor_en", ball_en, 9'b000000100);
    drive(0, 1, 0);
    settle();
    check("over_cleared", ball_en, 0);
    c_ty = 40;
    drive(0, 1, 1);
    repeat (6) drive(0, 1, 0);
    settle();
    check("over_no_spawn", ball_en, 0);
    drive(1, 1, 0);
    drive(0, 1, 0);
    settle();
    check("rst_health", target_health, 100);
    check("rst_alive", target_alive, 1);

    // randomized play
    for (int t = 0; t < 1500; t++) begin
      c_sy = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) c_ty = $urandom_range(0, 63);
      c_sh = ($urandom_range(0, 4) == 0);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 99) < 40));
    end

    settle();
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
